booth_multiplier: RTL and testbench

Sequential signed 32×32→64 multiplier implementing radix-2 Booth recoding, one partial-product step per clock. It feeds the HI/LO register pair of the multicycle datapath through the div/mult select mux and is sequenced by the control unit via a start/end handshake. It serves MULT: operands come from the A and B registers, the high product word goes to HI, and the low product word goes to LO.

---
 rtl/booth_multiplier.sv | 144 ++++++++++++++
 tb/tb_booth_multiplier.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier using
// radix-2 Booth recoding, one partial-product step per clock. A start/end
// handshake sequences it; the product lands in the HI/LO output registers.
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mult_start,
  output logic             mult_end,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_last_step;

  // Accumulator and multiplicand carry one extra bit so that subtracting
  // the most negative multiplicand cannot overflow.
  logic [WIDTH:0]   r_mcand;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q_1;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc_sh;
  logic [WIDTH-1:0] w_q_sh;
  logic             w_q1_sh;

  // Next-state logic; flags the final Booth step so the product can be captured.
  always_comb begin
    w_next_state = r_state;
    w_last_step  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mult_start) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = S_DONE;
          w_last_step  = 1'b1;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // One Booth step: add/subtract selected by {q[0], q_1}, then arithmetic shift right.
  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_q_1})
      2'b01:   w_sum = r_acc + r_mcand;
      2'b10:   w_sum = r_acc - r_mcand;
      default: w_sum = r_acc;
    endcase
    w_acc_sh = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_q_sh   = {w_sum[0], r_q[WIDTH-1:1]};
    w_q1_sh  = r_q[0];
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Booth datapath: operands latch only on start acceptance, then one step per RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_q_1   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mult_start) begin
            r_mcand <= {A[WIDTH-1], A};
            r_acc   <= '0;
            r_q     <= B;
            r_q_1   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_sh;
          r_q   <= w_q_sh;
          r_q_1 <= w_q1_sh;
          r_cnt <= r_cnt + CW'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Registered handshake outputs and product capture on the final step only.
  always_ff @(posedge clock) begin
    if (reset) begin
      mult_end <= 1'b0;
      busy     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      mult_end <= (w_next_state == S_DONE);
      busy     <= (w_next_state != S_IDLE);
      if (w_last_step) begin
        HI <= w_acc_sh[WIDTH-1:0];
        LO <= w_q_sh;
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed, scoreboard-based bench for booth_multiplier (WIDTH=32).
module tb_booth_multiplier;

  logic        clock;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        mult_start;
  logic        mult_end;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int          checks;
  int          failures;
  logic [63:0] exp_q[$];
  logic [63:0] last_prod;

  booth_multiplier #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .mult_start (mult_start),
    .mult_end   (mult_end),
    .busy       (busy),
    .HI         (HI),
    .LO         (LO)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference product: plain signed 64-bit multiply.
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = sa * sb;
    exp_q.push_back(p);
  endtask

  // Check busy/mult_end for this cycle; pop the scoreboard on completion and
  // otherwise require HI/LO to hold the last product.
  task automatic sample_cycle(input bit eb, input bit ee, input string tag);
    check({tag, "/busy"}, 64'(busy), 64'(eb));
    check({tag, "/mult_end"}, 64'(mult_end), 64'(ee));
    if (ee) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL %s/scoreboard observed=empty expected=entry", tag);
      end
      if (exp_q.size() > 0) begin
        last_prod = exp_q.pop_front();
      end
    end
    check({tag, "/HI_LO"}, {HI, LO}, last_prod);
  endtask

  // One operation from a start in the current cycle (cycle 0) through cycle 34.
  // restart_cyc > 0 re-pulses mult_start with 9x9 at that cycle and scrambles A/B.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int restart_cyc, input string tag);
    A = a;
    B = b;
    mult_start = 1'b1;
    push_exp(a, b);
    tick();
    mult_start = 1'b0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      sample_cycle(cyc <= 33, cyc == 33, tag);
      if (cyc < 34) begin
        if (cyc == restart_cyc) begin
          mult_start = 1'b1;
          A = 32'd9;
          B = 32'd9;
        end else begin
          mult_start = 1'b0;
          if (restart_cyc > 0) begin
            A = $urandom;
            B = $urandom;
          end
        end
        tick();
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    last_prod  = 64'd0;
    reset      = 1'b1;
    mult_start = 1'b0;
    A          = 32'd0;
    B          = 32'd0;
    tick();
    tick();
    check("reset/HI", 64'(HI), 64'd0);
    check("reset/LO", 64'(LO), 64'd0);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/mult_end", 64'(mult_end), 64'd0);
    reset = 1'b0;
    tick();

    run_op(32'd3, 32'd5, 0, "small_pos");
    check("small_pos/const", {HI, LO}, 64'h00000000_0000000F);
    run_op(32'hFFFFFFF9, 32'd6, 0, "mixed_sign");
    check("mixed_sign/const", {HI, LO}, 64'hFFFFFFFF_FFFFFFD6);
    run_op(32'h80000000, 32'h80000000, 0, "min_min");
    check("min_min/const", {HI, LO}, 64'h40000000_00000000);
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 0, "max_max");
    check("max_max/const", {HI, LO}, 64'h3FFFFFFF_00000001);
    run_op(32'h80000000, 32'h7FFFFFFF, 0, "min_max");
    check("min_max/const", {HI, LO}, 64'hC0000000_80000000);

    // Ignored re-start at cycle 10 with operands changing every cycle.
    run_op(32'd4, 32'd4, 10, "ignored_start");
    for (int cyc = 35; cyc <= 45; cyc++) begin
      sample_cycle(1'b0, 1'b0, "ignored_idle");
      tick();
    end
    check("ignored_start/const", {HI, LO}, 64'd16);

    // Reset asserted during cycle 20 of a 100x100 run: product discarded.
    A = 32'd100;
    B = 32'd100;
    mult_start = 1'b1;
    tick();
    mult_start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 21) begin
        last_prod = 64'd0;
      end
      sample_cycle(cyc <= 20, 1'b0, "reset_mid");
      reset = (cyc == 20);
      if (cyc < 40) begin
        tick();
      end
    end

    // Reset and mult_start at the same edge: reset wins.
    reset = 1'b1;
    mult_start = 1'b1;
    A = 32'd7;
    B = 32'd7;
    tick();
    reset = 1'b0;
    mult_start = 1'b0;
    sample_cycle(1'b0, 1'b0, "reset_vs_start");
    tick();
    sample_cycle(1'b0, 1'b0, "reset_vs_start2");

    run_op(32'd2, 32'd3, 0, "after_reset");
    check("after_reset/const", {HI, LO}, 64'd6);

    // Level-held mult_start: back-to-back -1 x -1.
    A = 32'hFFFFFFFF;
    B = 32'hFFFFFFFF;
    mult_start = 1'b1;
    push_exp(A, B);
    tick();
    for (int cyc = 1; cyc <= 102; cyc++) begin
      if ((cyc % 34 == 0) && (cyc < 102)) begin
        push_exp(A, B);
      end
      sample_cycle((cyc % 34) != 0, (cyc % 34) == 33, "back_to_back");
      if (cyc == 101) begin
        mult_start = 1'b0;
      end
      if (cyc < 102) begin
        tick();
      end
    end
    check("back_to_back/const", {HI, LO}, 64'd1);
    check("scoreboard/drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
